motor602_uart_cmd_rx: RTL and testbench
=======================================

MOTOR602_UART_CMD_RX -- requirements
Module: motor602_uart_cmd_rx

Interface
REQ-001 SHALL have params: CLK_HZ, default 50_000_000, core clock frequency; BAUD, default 115200, line rate; PULSE_CYC, default 50_000, width of INC/DEC command pulses in clocks.
REQ-002 SHALL have ports, one clock, reset synchronous and active-low:
- clk50mhzI  in  1  50 MHz clock.
- nRstI  in  1  synchronous active-low reset.
- uRxI  in  1  UART RX line, idle high, asynchronous.
- m3startO  out  1  start level.
- m3forceStopO  out  1  force-stop level.
- m3invRotateO  out  1  rotation-invert level.
- m3speedINCo, m3speedDECo, m3powerINCo, m3powerDECo  out  1 each  button-like pulses.
- rxByteO  out  8  last received byte.
- rxValidO  out  1  one-cycle strobe, rxByteO valid.
- frameErrO  out  1  one-cycle strobe, bad stop bit.

Function
REQ-003 SHALL pass uRxI through a 2-flop synchronizer before any use; this adds 2 cycles of latency.
REQ-004 SHALL use BIT_CYC = CLK_HZ/BAUD, which is 434, and HALF_CYC = BIT_CYC/2, which is 217.
REQ-005 SHALL implement FSM IDLE, START, DATA, STOP, WAITHI.
REQ-006 In IDLE, a synchronized falling edge SHALL go to START.
REQ-007 In START, the FSM SHALL wait HALF_CYC clocks and then sample: low goes to DATA, high returns to IDLE with no strobe (glitch reject).
REQ-008 In DATA, the FSM SHALL sample 8 bits LSB-first, one every BIT_CYC clocks.
REQ-009 In STOP, the FSM SHALL sample after BIT_CYC clocks:
- High: load rxByteO, pulse rxValidO for 1 cycle, go to IDLE.
- Low: pulse frameErrO for 1 cycle, leave rxByteO unchanged, go to WAITHI.
REQ-010 WAITHI SHALL stay until the synchronized line reads high, then go to IDLE; a break SHALL NOT produce repeated frames.
REQ-011 The cycle after rxValidO, bytes SHALL be decoded as follows:
- 'S' (0x53): m3startO=1, m3forceStopO=0.
- 'X' (0x58): m3startO=0, m3forceStopO=1.
- 'R' (0x52): toggle m3invRotateO.
- '+' (0x2B): pulse m3speedINCo.
- '-' (0x2D): pulse m3speedDECo.
- 'P' (0x50): pulse m3powerINCo.
- 'p' (0x70): pulse m3powerDECo.
- Any other byte: no output change.
REQ-012 Each pulse output SHALL stay high for exactly PULSE_CYC clocks, timed by one shared down-counter.
REQ-013 At most one pulse output SHALL be high at a time; a new pulse command received while a pulse is active SHALL drop the old output and restart the counter for the new one in the same cycle.
REQ-014 A non-pulse command received while a pulse is active SHALL update the levels and leave the active pulse untouched.
REQ-015 Bit counter and baud counter SHALL NOT wrap; both are cleared on every FSM state entry.

Reset
REQ-016 With nRstI=0 at a clock edge, the block SHALL:
- Set FSM to IDLE and clear all counters.
- Drive every output to 0, including rxByteO=0x00 and m3invRotateO=0.
- Preset synchronizer flops to 1.
REQ-017 A reset mid-frame or mid-pulse SHALL abort the operation immediately, with no strobe emitted.

Configuration
REQ-018 With UART_RX_GLITCH_FILTER_EN defined, each START, DATA and STOP sample SHALL be the 2-of-3 majority of samples taken at center-1, center and center+1; every strobe is then 1 cycle later.
REQ-019 Without UART_RX_GLITCH_FILTER_EN, each sample SHALL be the single value at center.

Structure
REQ-020 Package motor602_uart_pkg SHALL hold the FSM state enum, the BIT_CYC/HALF_CYC computation and the command byte constants.
REQ-021 Byte reception SHALL be a sub-module motor602_uart_rx_core covering REQ-003..010 and REQ-018/019; command decode and the pulse timer SHALL stay in the top.

Verification
REQ-022 Send 0x53 at 115200 baud, 8N1: rxValidO pulses with rxByteO=0x53, and m3startO=1 one cycle later with m3forceStopO=0.
REQ-023 Send 0x2B: m3speedINCo is high for exactly 50_000 clocks; send 0x2D 10_000 clocks into that pulse: m3speedINCo falls in the same cycle m3speedDECo rises, and m3speedDECo lasts 50_000 clocks.
REQ-024 Send 0x52 twice: m3invRotateO goes 0->1->0.
REQ-025 Send 0x58 with the stop bit forced low: frameErrO pulses once, no rxValidO, outputs unchanged; hold the line low for 5 more bit times: no further strobes, and the next clean 0x53 is received.
REQ-026 Drive a 100-clock low glitch on an idle line: no rxValidO and no frameErrO.
REQ-027 Assert nRstI during bit 4 of 0x50: no strobe and all outputs 0; the following 0x50 produces a 50_000-clock m3powerINCo pulse.

Source files
------------

// File: rtl/motor602_uart_pkg.sv
// motor602_uart_pkg: shared receiver state enum, baud timing helpers and command byte codes
package motor602_uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} rxState_t;

    function automatic int bitCyc(input int clkHz, input int baud);
        return clkHz / baud;
    endfunction

    localparam int BIT_CYC  = bitCyc(50_000_000, 115200);
    localparam int HALF_CYC = BIT_CYC / 2;

    localparam logic [7:0] CMD_START     = 8'h53;
    localparam logic [7:0] CMD_STOP      = 8'h58;
    localparam logic [7:0] CMD_INV       = 8'h52;
    localparam logic [7:0] CMD_SPEED_INC = 8'h2B;
    localparam logic [7:0] CMD_SPEED_DEC = 8'h2D;
    localparam logic [7:0] CMD_POWER_INC = 8'h50;
    localparam logic [7:0] CMD_POWER_DEC = 8'h70;

    // one-hot pulse selection {powerDec, powerInc, speedDec, speedInc}; zero for non-pulse bytes
    function automatic logic [3:0] pulseOf(input logic [7:0] b);
        return b == CMD_SPEED_INC ? 4'b0001 :
               b == CMD_SPEED_DEC ? 4'b0010 :
               b == CMD_POWER_INC ? 4'b0100 :
               b == CMD_POWER_DEC ? 4'b1000 : 4'b0000;
    endfunction

endpackage

// File: rtl/motor602_uart_rx_core.sv
// motor602_uart_rx_core: 8N1 UART byte receiver; UART_RX_GLITCH_FILTER_EN enables 2-of-3 majority sampling
module motor602_uart_rx_core
    import motor602_uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       rxAsync,
    output logic [7:0] rxByte,
    output logic       rxValid,
    output logic       frameErr
);

`ifdef UART_RX_GLITCH_FILTER_EN
    localparam int FILT = 1;
`else
    localparam int FILT = 0;
`endif
    localparam int BIT_C = bitCyc(CLK_HZ, BAUD);
    localparam int HALF_C = BIT_C / 2;
    localparam int CW = $clog2(BIT_C + 1);
    localparam int SW = 3 + FILT;
    // the majority decision lands one clock after the centre, so only the start
    // sample is pushed back; later bits keep exact BIT_C spacing from there
    localparam logic [CW-1:0] START_END = CW'(HALF_C - 1 + FILT);
    localparam logic [CW-1:0] BIT_END = CW'(BIT_C - 1);

    rxState_t state;
    logic [SW-1:0] syncSh;
    logic [CW-1:0] cnt;
    logic [2:0] bitIdx;
    logic [7:0] dataSh;
    logic rxS, fall, sample;

    assign rxS = syncSh[1];
    assign fall = syncSh[2] & ~rxS;
`ifdef UART_RX_GLITCH_FILTER_EN
    assign sample = (rxS & syncSh[2]) | (rxS & syncSh[3]) | (syncSh[2] & syncSh[3]);
`else
    assign sample = rxS;
`endif

    // synchronizer, frame FSM, bit/baud counters and registered strobes
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state <= IDLE;
            syncSh <= '1;
            cnt <= '0;
            bitIdx <= '0;
            dataSh <= '0;
            rxByte <= '0;
            rxValid <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            syncSh <= {syncSh[SW-2:0], rxAsync};
            rxValid <= 1'b0;
            frameErr <= 1'b0;
            cnt <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    bitIdx <= '0;
                    if (fall) state <= START;
                end
                START: if (cnt == START_END) begin
                    cnt <= '0;
                    bitIdx <= '0;
                    state <= sample ? IDLE : DATA;
                end
                DATA: if (cnt == BIT_END) begin
                    cnt <= '0;
                    dataSh <= {sample, dataSh[7:1]};
                    bitIdx <= (bitIdx == 3'd7) ? 3'd0 : bitIdx + 3'd1;
                    if (bitIdx == 3'd7) state <= STOP;
                end
                STOP: if (cnt == BIT_END) begin
                    cnt <= '0;
                    if (sample) begin
                        rxByte <= dataSh;
                        rxValid <= 1'b1;
                        state <= IDLE;
                    end else begin
                        frameErr <= 1'b1;
                        state <= WAITHI;
                    end
                end
                WAITHI: begin
                    cnt <= '0;
                    if (rxS) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/motor602_uart_cmd_rx.sv
// motor602_uart_cmd_rx: UART command receiver driving motor levels and timed button pulses; optional UART_RX_GLITCH_FILTER_EN
module motor602_uart_cmd_rx
    import motor602_uart_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int PULSE_CYC = 50_000
) (
    input  logic       clk50mhzI,
    input  logic       nRstI,
    input  logic       uRxI,
    output logic       m3startO,
    output logic       m3forceStopO,
    output logic       m3invRotateO,
    output logic       m3speedINCo,
    output logic       m3speedDECo,
    output logic       m3powerINCo,
    output logic       m3powerDECo,
    output logic [7:0] rxByteO,
    output logic       rxValidO,
    output logic       frameErrO
);

    localparam int PW = $clog2(PULSE_CYC + 1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYC - 1);

    logic [3:0] pulse, newPulse;
    logic [PW-1:0] pulseCnt;

    motor602_uart_rx_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) rxCore (
        .clk(clk50mhzI),
        .nRst(nRstI),
        .rxAsync(uRxI),
        .rxByte(rxByteO),
        .rxValid(rxValidO),
        .frameErr(frameErrO)
    );

    assign newPulse = pulseOf(rxByteO);
    assign {m3powerDECo, m3powerINCo, m3speedDECo, m3speedINCo} = pulse;

    // command decode: levels update on any received byte, pulses share one down-counter
    always_ff @(posedge clk50mhzI) begin
        if (!nRstI) begin
            pulse <= '0;
            pulseCnt <= '0;
            m3startO <= 1'b0;
            m3forceStopO <= 1'b0;
            m3invRotateO <= 1'b0;
        end else begin
            if (rxValidO && newPulse != 4'b0000) begin
                pulse <= newPulse;
                pulseCnt <= PULSE_LOAD;
            end else if (pulse != 4'b0000) begin
                if (pulseCnt == '0) pulse <= '0;
                else pulseCnt <= pulseCnt - 1'b1;
            end
            if (rxValidO && rxByteO == CMD_START) begin
                m3startO <= 1'b1;
                m3forceStopO <= 1'b0;
            end
            if (rxValidO && rxByteO == CMD_STOP) begin
                m3startO <= 1'b0;
                m3forceStopO <= 1'b1;
            end
            if (rxValidO && rxByteO == CMD_INV) m3invRotateO <= ~m3invRotateO;
        end
    end

endmodule

// File: tb/tb_motor602_uart_cmd_rx.sv
// tb_motor602_uart_cmd_rx: table-driven UART command bench with a received-byte scoreboard
module tb_motor602_uart_cmd_rx;

    localparam int BIT = 434;
    localparam int PC = 6000;

    typedef struct packed {
        logic [7:0] b;
        logic st;
        logic fs;
        logic inv;
    } exp_t;

    logic clk = 1'b0, nRst = 1'b0, uRx = 1'b1;
    logic m3startO, m3forceStopO, m3invRotateO;
    logic m3speedINCo, m3speedDECo, m3powerINCo, m3powerDECo;
    logic [7:0] rxByteO;
    logic rxValidO, frameErrO;

    int nCmp = 0, nErr = 0;
    exp_t q[$];
    exp_t e;
    exp_t tbl[6];
    int rxCnt = 0, feCnt = 0;
    logic [3:0] p, prevP = 4'b0;
    int run[4], lastLen[4], done[4];
    int multiHot = 0;
    logic handOk = 1'b0;
    int rx0, fe0, d0, inc0;

    always #10 clk = ~clk;

    motor602_uart_cmd_rx #(.PULSE_CYC(PC)) dut (
        .clk50mhzI(clk),
        .nRstI(nRst),
        .uRxI(uRx),
        .m3startO(m3startO),
        .m3forceStopO(m3forceStopO),
        .m3invRotateO(m3invRotateO),
        .m3speedINCo(m3speedINCo),
        .m3speedDECo(m3speedDECo),
        .m3powerINCo(m3powerINCo),
        .m3powerDECo(m3powerDECo),
        .rxByteO(rxByteO),
        .rxValidO(rxValidO),
        .frameErrO(frameErrO)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // frame driven LSB-first; the line is left at the stop-bit level
    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        uRx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uRx = b[i];
            repeat (BIT) @(posedge clk);
        end
        uRx = stopBit;
        repeat (BIT) @(posedge clk);
    endtask

    // scoreboard: every received byte must match the next queued entry, levels checked a cycle later
    initial forever begin
        @(negedge clk);
        if (frameErrO) feCnt++;
        if (rxValidO) begin
            rxCnt++;
            check("rxExpected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("rxByte", rxByteO, e.b);
                @(negedge clk);
                check("levels", {m3startO, m3forceStopO, m3invRotateO}, {e.st, e.fs, e.inv});
            end
        end
    end

    // pulse watcher: run lengths, exclusivity and the INC->DEC handoff
    initial forever begin
        @(negedge clk);
        p = {m3powerDECo, m3powerINCo, m3speedDECo, m3speedINCo};
        if ($countones(p) > 1) multiHot++;
        if (p[1] && !prevP[1]) handOk = prevP[0] && !p[0];
        for (int k = 0; k < 4; k++) begin
            if (p[k]) run[k]++;
            if (prevP[k] && !p[k]) begin
                lastLen[k] = run[k];
                run[k] = 0;
                done[k]++;
            end
        end
        prevP = p;
    end

    initial begin
        tbl[0] = '{8'h53, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h52, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{8'h41, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{8'h58, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{8'h52, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{8'h52, 1'b0, 1'b1, 1'b1};
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rstOuts", {m3startO, m3forceStopO, m3invRotateO, m3speedINCo, m3speedDECo,
                          m3powerINCo, m3powerDECo, rxValidO, frameErrO}, 0);
        check("rstByte", rxByteO, 8'h00);
        @(posedge clk);
        nRst = 1'b1;
        repeat (20) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            q.push_back(tbl[i]);
            sendByte(tbl[i].b, 1'b1);
            repeat (10) @(posedge clk);
        end
        check("tableRxCount", rxCnt, 6);

        q.push_back('{8'h2B, 1'b0, 1'b1, 1'b1});
        inc0 = done[0];
        sendByte(8'h2B, 1'b1);
        repeat (10) @(posedge clk);
        q.push_back('{8'h2D, 1'b0, 1'b1, 1'b1});
        d0 = done[1];
        sendByte(8'h2D, 1'b1);
        for (int i = 0; i < PC + 2000 && done[1] == d0; i++) @(negedge clk);
        check("decEnded", done[1] - d0, 1);
        check("decLen", lastLen[1], PC);
        check("incEnded", done[0] - inc0, 1);
        check("incCutLen", lastLen[0], 10 * BIT + 10);
        check("handoff", handOk, 1);

        rx0 = rxCnt;
        fe0 = feCnt;
        sendByte(8'h58, 1'b0);
        check("frameErrOnce", feCnt - fe0, 1);
        repeat (5 * BIT) @(posedge clk);
        check("breakNoRepeat", feCnt - fe0, 1);
        check("breakNoRx", rxCnt - rx0, 0);
        check("breakLevels", {m3startO, m3forceStopO, m3invRotateO}, 3'b011);
        check("breakByteKept", rxByteO, 8'h2D);
        uRx = 1'b1;
        repeat (50) @(posedge clk);
        q.push_back('{8'h53, 1'b1, 1'b0, 1'b1});
        sendByte(8'h53, 1'b1);
        repeat (10) @(posedge clk);
        check("afterBreakRx", rxCnt - rx0, 1);

        rx0 = rxCnt;
        fe0 = feCnt;
        uRx = 1'b0;
        repeat (100) @(posedge clk);
        uRx = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        check("glitchNoRx", rxCnt - rx0, 0);
        check("glitchNoFe", feCnt - fe0, 0);

        uRx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 4; i++) repeat (BIT) @(posedge clk);
        uRx = 1'b1;
        repeat (BIT / 2) @(posedge clk);
        nRst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midRstOuts", {m3startO, m3forceStopO, m3invRotateO, m3speedINCo, m3speedDECo,
                             m3powerINCo, m3powerDECo, rxValidO, frameErrO}, 0);
        check("midRstByte", rxByteO, 8'h00);
        @(posedge clk);
        nRst = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        check("midRstNoRx", rxCnt - rx0, 0);
        check("midRstNoFe", feCnt - fe0, 0);
        q.push_back('{8'h50, 1'b0, 1'b0, 1'b0});
        d0 = done[2];
        sendByte(8'h50, 1'b1);
        for (int i = 0; i < PC + 2000 && done[2] == d0; i++) @(negedge clk);
        check("powIncEnded", done[2] - d0, 1);
        check("powIncLen", lastLen[2], PC);
        check("oneHot", multiHot, 0);
        check("queueDrained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
